// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache with line-wide memory handshake
module dcache_ctrl #(
    parameter int INDEX_W = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [31:0]   cpu_addr_i,
    input  logic [31:0]   cpu_data_i,
    output logic [31:0]   cpu_data_o,
    output logic          cpu_stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_addr_o,
    output logic [127:0]  mem_data_o,
    input  logic [127:0]  mem_data_i,
    input  logic          mem_ack_i
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t               state_q, state_d;
    logic [LINES-1:0]     valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q [LINES];
    logic [127:0]         data_q [LINES];

    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   idx;
    logic [1:0]           off;
    logic                 hit, refill, store_hit;
    logic                 unused_byte_bits;

    assign req_tag          = cpu_addr_i[31:4+INDEX_W];
    assign idx              = cpu_addr_i[3+INDEX_W:4];
    assign off              = cpu_addr_i[3:2];
    assign unused_byte_bits = ^cpu_addr_i[1:0];

    assign hit         = (state_q == IDLE) & valid_q[idx] & (tag_q[idx] == req_tag);
    assign refill      = (state_q == ALLOCATE) & mem_ack_i & ~rst_i;
    assign store_hit   = cpu_req_i & cpu_we_i & hit;
    assign cpu_stall_o = cpu_req_i & ~hit;
    assign cpu_data_o  = (cpu_req_i & hit & ~cpu_we_i) ? data_q[idx][{off, 5'b0} +: 32] : '0;
    assign mem_data_o  = data_q[idx];

    // Miss sequencing: victim write-back when dirty, then line fetch; memory outputs follow the state
    always_comb begin
        state_d    = state_q;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = {req_tag, idx, 4'b0};
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit)
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {tag_q[idx], idx, 4'b0};
                if (mem_ack_i)
                    state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req_o = 1'b1;
                if (mem_ack_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any transfer in flight
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Line status: refill makes a line valid and clean, a store hit marks it dirty
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (refill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Line contents and tags are left uninitialised; valid guards every use
    always_ff @(posedge clk_i) begin
        if (refill) begin
            data_q[idx] <= mem_data_i;
            tag_q[idx]  <= req_tag;
        end else if (store_hit) begin
            data_q[idx][{off, 5'b0} +: 32] <= cpu_data_i;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and random checks of dcache_ctrl against a transparent-memory reference model
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i, cpu_req_i, cpu_we_i, mem_ack_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o, mem_addr_o;
    logic         cpu_stall_o, mem_req_o, mem_we_o;
    logic [127:0] mem_data_o, mem_data_i;

    int checks = 0;
    int errors = 0;

    dcache_ctrl #(.INDEX_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .cpu_stall_o(cpu_stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // main memory lines, architectural word values, and which lines the cache should hold
    logic [127:0] mem_line [logic [27:0]];
    logic [31:0]  arch_w [logic [29:0]];
    bit           rv [16];
    bit           rd [16];
    logic [23:0]  rt [16];

    int           e_stalls, e_ntr;
    bit           e_hit, e_wb;
    logic [31:0]  e_data, e_wb_addr, e_fetch_addr;
    logic [127:0] e_wb_data;

    int           o_stalls, o_ntr, o_unstable;
    bit           o_done, o_reqhit;
    logic [31:0]  o_data;
    logic         o_tw [4];
    logic [31:0]  o_ta [4];
    logic [127:0] o_td [4];

    function automatic logic [127:0] get_line(input logic [27:0] la);
        if (!mem_line.exists(la)) mem_line[la] = {$urandom, $urandom, $urandom, $urandom};
        return mem_line[la];
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        logic [127:0] l;
        if (arch_w.exists(a[31:2])) return arch_w[a[31:2]];
        l = get_line(a[31:4]);
        return l[32*a[3:2] +: 32];
    endfunction

    function automatic logic [127:0] arch_line(input logic [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = arch_rd({la, w[1:0], 2'b00});
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            rv[i] = 0;
            rd[i] = 0;
        end
        arch_w.delete();
    endtask

    task automatic predict(input bit we, input logic [31:0] a, input int lwb, input int lf);
        int i = int'(a[7:4]);
        e_hit        = rv[i] && rt[i] == a[31:8];
        e_wb         = !e_hit && rv[i] && rd[i];
        e_stalls     = e_hit ? 0 : 1 + (e_wb ? lwb + 1 : 0) + lf + 1;
        e_ntr        = e_hit ? 0 : (e_wb ? 2 : 1);
        e_data       = we ? 32'h0 : arch_rd(a);
        e_wb_addr    = {rt[i], a[7:4], 4'h0};
        e_wb_data    = e_wb ? arch_line({rt[i], a[7:4]}) : 128'h0;
        e_fetch_addr = {a[31:4], 4'h0};
    endtask

    task automatic commit(input bit we, input logic [31:0] a, input logic [31:0] wd);
        int i = int'(a[7:4]);
        if (!(rv[i] && rt[i] == a[31:8])) begin
            rv[i] = 1;
            rt[i] = a[31:8];
            rd[i] = 0;
        end
        if (we) begin
            arch_w[a[31:2]] = wd;
            rd[i] = 1;
        end
    endtask

    // holds one CPU request until it completes, acting as memory with the given ack latencies
    task automatic run(input bit we, input logic [31:0] a, input logic [31:0] wd, input int lwb, input int lf);
        int cnt = 0;
        logic cw = 1'b0;
        logic [31:0] ca = '0;
        logic [127:0] cd = '0;
        o_stalls = 0; o_ntr = 0; o_unstable = 0; o_done = 0; o_reqhit = 0; o_data = '0;
        cpu_req_i = 1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = wd;
        for (int c = 0; c < 200 && !o_done; c++) begin
            #1;
            if (mem_req_o) begin
                if (cnt == 0) begin
                    cw = mem_we_o; ca = mem_addr_o; cd = mem_data_o;
                    if (o_ntr < 4) begin
                        o_tw[o_ntr] = cw; o_ta[o_ntr] = ca; o_td[o_ntr] = cd;
                    end
                end else if (mem_we_o !== cw || mem_addr_o !== ca || (cw && mem_data_o !== cd)) begin
                    o_unstable++;
                end
                if (cnt == (cw ? lwb : lf)) begin
                    mem_ack_i = 1;
                    if (cw) mem_line[ca[31:4]] = cd;
                    else mem_data_i = get_line(ca[31:4]);
                    o_ntr++;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
            if (!cpu_stall_o) begin
                o_data = cpu_data_o; o_reqhit = mem_req_o; o_done = 1;
            end else begin
                o_stalls++;
            end
            @(posedge clk_i);
            @(negedge clk_i);
            mem_ack_i = 0;
        end
        cpu_req_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
        mem_ack_i = 0; mem_data_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
        #1;
        checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", cpu_stall_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we_o); end
        checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", cpu_data_o); end
        cpu_req_i = 1; cpu_addr_i = 32'h0000_0104;
        #1;
        checks++; if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL reset_empty_miss got %b want 1", cpu_stall_o); end
        cpu_req_i = 0;
        @(negedge clk_i);
        model_reset();
    endtask

    task automatic test_first_load();
        mem_line[28'h10] = {32'h33, 32'h22, 32'h11, 32'h00};
        run(0, 32'h104, 0, 0, 5);
        checks++; if (!o_done) begin errors++; $display("FAIL first_load_timeout got stuck want done"); end
        checks++; if (o_stalls !== 7) begin errors++; $display("FAIL first_load_stall got %0d want 7", o_stalls); end
        checks++; if (o_ntr !== 1 || o_tw[0] !== 1'b0 || o_ta[0] !== 32'h100) begin
            errors++; $display("FAIL first_load_alloc got n=%0d we=%b addr=%h want n=1 we=0 addr=00000100", o_ntr, o_tw[0], o_ta[0]);
        end
        checks++; if (o_data !== 32'h11) begin errors++; $display("FAIL first_load_data got %h want 00000011", o_data); end
        commit(0, 32'h104, 0);
        run(0, 32'h108, 0, 0, 5);
        checks++; if (o_stalls !== 0 || o_ntr !== 0) begin errors++; $display("FAIL reload_hit got stalls=%0d n=%0d want 0 0", o_stalls, o_ntr); end
        checks++; if (o_data !== 32'h22) begin errors++; $display("FAIL reload_data got %h want 00000022", o_data); end
    endtask

    task automatic test_store_hit();
        run(1, 32'h10C, 32'hDEADBEEF, 0, 0);
        checks++; if (o_stalls !== 0 || o_ntr !== 0) begin errors++; $display("FAIL store_hit got stalls=%0d n=%0d want 0 0", o_stalls, o_ntr); end
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL store_hit_data got %h want 0", o_data); end
        commit(1, 32'h10C, 32'hDEADBEEF);
        run(0, 32'h10C, 0, 0, 0);
        checks++; if (o_stalls !== 0 || o_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_readback got stalls=%0d data=%h want 0 deadbeef", o_stalls, o_data);
        end
    endtask

    task automatic test_dirty_evict();
        run(0, 32'h1100, 0, 2, 3);
        checks++; if (o_ntr !== 2 || o_tw[0] !== 1'b1 || o_ta[0] !== 32'h100) begin
            errors++; $display("FAIL evict_wb got n=%0d we=%b addr=%h want n=2 we=1 addr=00000100", o_ntr, o_tw[0], o_ta[0]);
        end
        checks++; if (o_td[0] !== {32'hDEADBEEF, 32'h22, 32'h11, 32'h00}) begin
            errors++; $display("FAIL evict_wb_data got %h want deadbeef000000220000001100000000", o_td[0]);
        end
        checks++; if (o_tw[1] !== 1'b0 || o_ta[1] !== 32'h1100) begin
            errors++; $display("FAIL evict_alloc got we=%b addr=%h want we=0 addr=00001100", o_tw[1], o_ta[1]);
        end
        checks++; if (o_stalls !== 8) begin errors++; $display("FAIL evict_stall got %0d want 8", o_stalls); end
        checks++; if (o_unstable !== 0) begin errors++; $display("FAIL evict_stable got %0d changes want 0", o_unstable); end
        commit(0, 32'h1100, 0);
    endtask

    task automatic test_clean_conflict();
        run(0, 32'h100, 0, 0, 1);
        checks++; if (o_ntr !== 1 || o_tw[0] !== 1'b0 || o_ta[0] !== 32'h100) begin
            errors++; $display("FAIL clean_conflict got n=%0d we=%b addr=%h want n=1 we=0 addr=00000100", o_ntr, o_tw[0], o_ta[0]);
        end
        checks++; if (o_stalls !== 3 || o_data !== 32'h0) begin
            errors++; $display("FAIL clean_conflict_result got stalls=%0d data=%h want 3 00000000", o_stalls, o_data);
        end
        commit(0, 32'h100, 0);
    endtask

    task automatic test_store_miss();
        run(1, 32'h204, 32'hCAFE0001, 0, 2);
        checks++; if (o_ntr !== 1 || o_tw[0] !== 1'b0 || o_ta[0] !== 32'h200 || o_stalls !== 4) begin
            errors++; $display("FAIL store_miss got n=%0d we=%b addr=%h stalls=%0d want 1 0 00000200 4", o_ntr, o_tw[0], o_ta[0], o_stalls);
        end
        commit(1, 32'h204, 32'hCAFE0001);
        predict(0, 32'h1200, 1, 1);
        run(0, 32'h1200, 0, 1, 1);
        checks++; if (o_ntr !== 2 || o_tw[0] !== 1'b1 || o_ta[0] !== 32'h200) begin
            errors++; $display("FAIL merged_evict got n=%0d we=%b addr=%h want 2 1 00000200", o_ntr, o_tw[0], o_ta[0]);
        end
        checks++; if (o_td[0][63:32] !== 32'hCAFE0001 || o_td[0] !== e_wb_data) begin
            errors++; $display("FAIL merged_evict_data got %h want %h", o_td[0], e_wb_data);
        end
        checks++; if (o_stalls !== 5 || o_data !== e_data) begin
            errors++; $display("FAIL merged_evict_load got stalls=%0d data=%h want 5 %h", o_stalls, o_data, e_data);
        end
        commit(0, 32'h1200, 0);
    endtask

    task automatic test_reset_mid();
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h3040;
        #1;
        checks++; if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL rst_mid_miss got %b want 1", cpu_stall_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h3040) begin
            errors++; $display("FAIL rst_mid_alloc got req=%b we=%b addr=%h want 1 0 00003040", mem_req_o, mem_we_o, mem_addr_o);
        end
        rst_i = 1; cpu_req_i = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid_req_drop got %b want 0", mem_req_o); end
        mem_ack_i = 1; mem_data_i = {4{32'h5A5A5A5A}};
        @(posedge clk_i);
        @(negedge clk_i);
        mem_ack_i = 0;
        #1;
        checks++; if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_late_ack got req=%b stall=%b want 0 0", mem_req_o, cpu_stall_o);
        end
        model_reset();
        predict(0, 32'h3040, 0, 2);
        run(0, 32'h3040, 0, 0, 2);
        checks++; if (o_stalls !== 4 || o_ntr !== 1 || o_ta[0] !== 32'h3040) begin
            errors++; $display("FAIL rst_mid_remiss got stalls=%0d n=%0d addr=%h want 4 1 00003040", o_stalls, o_ntr, o_ta[0]);
        end
        checks++; if (o_data !== e_data) begin errors++; $display("FAIL rst_mid_data got %h want %h", o_data, e_data); end
        commit(0, 32'h3040, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit we = 1'($urandom_range(0, 1));
            logic [23:0] tg = 24'($urandom_range(0, 2)) * 24'h10101;
            logic [3:0] ix = 4'($urandom_range(0, 3));
            logic [1:0] of = 2'($urandom_range(0, 3));
            logic [31:0] a = {tg, ix, of, 2'b00};
            logic [31:0] wd = $urandom;
            int lwb = $urandom_range(0, 4);
            int lf = $urandom_range(0, 4);
            predict(we, a, lwb, lf);
            run(we, a, wd, lwb, lf);
            checks++; if (!o_done) begin errors++; $display("FAIL rnd_timeout addr=%h got stuck want done", a); end
            checks++; if (o_stalls !== e_stalls) begin errors++; $display("FAIL rnd_stall addr=%h got %0d want %0d", a, o_stalls, e_stalls); end
            checks++; if (o_data !== e_data) begin errors++; $display("FAIL rnd_data addr=%h got %h want %h", a, o_data, e_data); end
            checks++; if (o_ntr !== e_ntr) begin errors++; $display("FAIL rnd_ntr addr=%h got %0d want %0d", a, o_ntr, e_ntr); end
            checks++; if (o_unstable !== 0 || o_reqhit !== 1'b0) begin
                errors++; $display("FAIL rnd_mem_hold addr=%h got changes=%0d req_at_hit=%b want 0 0", a, o_unstable, o_reqhit);
            end
            if (e_ntr > 0 && o_ntr == e_ntr) begin
                checks++; if (o_tw[e_ntr-1] !== 1'b0 || o_ta[e_ntr-1] !== e_fetch_addr) begin
                    errors++; $display("FAIL rnd_fetch got we=%b addr=%h want 0 %h", o_tw[e_ntr-1], o_ta[e_ntr-1], e_fetch_addr);
                end
            end
            if (e_wb && o_ntr == 2) begin
                checks++; if (o_tw[0] !== 1'b1 || o_ta[0] !== e_wb_addr || o_td[0] !== e_wb_data) begin
                    errors++; $display("FAIL rnd_wb got we=%b addr=%h data=%h want 1 %h %h", o_tw[0], o_ta[0], o_td[0], e_wb_addr, e_wb_data);
                end
            end
            commit(we, a, wd);
        end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_store_hit();
        test_dirty_evict();
        test_clean_conflict();
        test_store_miss();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
